// File: rtl/alu_pkg.sv
// Shared definitions for the sequential matrix negation unit: the FSM state
// type and the default geometry constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_ELEM_W = 8;
    localparam int DEF_DIM    = 5;
    localparam int DEF_LANES  = 5;

endpackage

// File: rtl/alu_negate_lane.sv
// One negation lane: two's-complement negate of a single element.
// The most negative input either wraps to itself or saturates to MAX.
module alu_negate_lane #(
    parameter int ELEM_W = 8
) (
    input  logic              sat_mode,
    input  logic [ELEM_W-1:0] a,
    output logic [ELEM_W-1:0] y,
    output logic              ovf
);

    localparam logic [ELEM_W-1:0] MIN_VAL = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic [ELEM_W-1:0] MAX_VAL = ~MIN_VAL;

    assign ovf = (a == MIN_VAL);
    assign y   = ovf ? (sat_mode ? MAX_VAL : MIN_VAL) : (ELEM_W'(0) - a);

endmodule

// File: rtl/alu_opposite_seq_module.sv
// Sequential matrix negation: captures a DIM x DIM matrix on start and
// negates LANES elements per cycle, pulsing done when the result is complete.
module alu_opposite_seq_module
    import alu_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int DIM    = DEF_DIM,
    parameter int LANES  = DEF_LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sat_mode,
    input  logic [DIM*DIM*ELEM_W-1:0] A_flat,
    output logic                      busy,
    output logic                      done,
    output logic [DIM*DIM*ELEM_W-1:0] C_flat,
    output logic [DIM*DIM-1:0]        overflow_mask,
    output logic                      overflow_flag
);

    localparam int N     = DIM * DIM;
    localparam int BEATS = (N + LANES - 1) / LANES;
    localparam int BW    = $clog2(BEATS) + 1;

    state_t                  state_reg;
    logic [BW-1:0]           beat_reg;
    logic [N*ELEM_W-1:0]     a_reg;
    logic                    sat_reg;
    logic [N*ELEM_W-1:0]     c_reg;
    logic [N-1:0]            mask_reg;
    logic                    done_reg;

    logic [ELEM_W-1:0]       lane_y [LANES];
    logic [LANES-1:0]        lane_ovf;

    // Each lane picks its element of the current beat from the captured
    // operand; lanes past the last element see zero and are never written back.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ELEM_W-1:0] a_sel;

        always_comb begin
            a_sel = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (beat_reg == BW'(b) && (b * LANES + gi) < N) begin
                    a_sel = a_reg[((b * LANES + gi < N) ? (b * LANES + gi) : 0) * ELEM_W +: ELEM_W];
                end
            end
        end

        alu_negate_lane #(
            .ELEM_W(ELEM_W)
        ) u_lane (
            .sat_mode(sat_reg),
            .a       (a_sel),
            .y       (lane_y[gi]),
            .ovf     (lane_ovf[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            a_reg     <= '0;
            sat_reg   <= 1'b0;
            c_reg     <= '0;
            mask_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= A_flat;
                        sat_reg   <= sat_mode;
                        c_reg     <= '0;
                        mask_reg  <= '0;
                        beat_reg  <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    beat_reg <= beat_reg + BW'(1);
                    for (int i = 0; i < N; i++) begin
                        if (beat_reg == BW'(i / LANES)) begin
                            c_reg[i*ELEM_W +: ELEM_W] <= lane_y[i % LANES];
                            mask_reg[i]               <= lane_ovf[i % LANES];
                        end
                    end
                    if (beat_reg == BW'(BEATS - 1)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign C_flat        = c_reg;
    assign overflow_mask = mask_reg;
    assign overflow_flag = |mask_reg;

endmodule

// File: doc/alu_opposite_seq_module.md
ALU_OPPOSITE_SEQ_MODULE -- requirements
Module: alu_opposite_seq_module

Interface
REQ-001 Parameter ELEM_W, default 8: signed two's-complement element width in bits, legal values 2..32.
REQ-002 Parameter DIM, default 5: the matrix is DIM x DIM, with N = DIM*DIM elements.
REQ-003 Parameter LANES, default 5: elements negated per cycle, legal values 1..N.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle operation request, sampled only in IDLE.
REQ-007 sat_mode  input  1  mode select: 0 = wrap, 1 = saturate; captured when start is accepted.
REQ-008 A_flat  input  N*ELEM_W  input matrix; element i occupies bits [i*ELEM_W +: ELEM_W]; captured when start is accepted.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking that the result is valid.
REQ-011 C_flat  output  N*ELEM_W  negated matrix, using the same element packing as A_flat.
REQ-012 overflow_mask  output  N  bit i set when element i equals the most negative value (MIN).
REQ-013 overflow_flag  output  1  OR-reduction of overflow_mask.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with reset state IDLE.
REQ-015 IDLE with start=1 SHALL: register A_flat and sat_mode into an operand buffer, clear C_flat and overflow_mask, set beat=0, and move to RUN.
REQ-016 BEATS = ceil(N/LANES); in RUN, each cycle SHALL process elements beat*LANES .. beat*LANES+LANES-1, ignore lanes with index >= N, then increment beat.
REQ-017 Processing the beat with index BEATS-1 SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-018 Latency: start accepted at cycle T implies done is high at cycle T+BEATS+1 (T+6 with the defaults).
REQ-019 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-020 start SHALL be ignored while busy is high, with no queuing and no restart.
REQ-021 Each element result SHALL be -a, computed modulo 2^ELEM_W.
REQ-022 For a = MIN: sat_mode=0 SHALL give MIN; sat_mode=1 SHALL give MAX (2^(ELEM_W-1)-1).
REQ-023 The overflow_mask bit SHALL be set for a = MIN in both modes; zero SHALL give zero with no overflow.
REQ-024 C_flat, overflow_mask and overflow_flag SHALL hold their values after done until the next accepted start.
REQ-025 Changes on A_flat or sat_mode after capture SHALL NOT affect the operation in progress.

Reset
REQ-026 rst=1 at any clock edge SHALL force state IDLE, beat=0, busy=0, done=0, C_flat=0, overflow_mask=0, overflow_flag=0, and clear the operand buffer.
REQ-027 Reset asserted during RUN SHALL abort the operation without a done pulse.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-029 Shared package alu_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default ELEM_W, DIM and LANES constants.
REQ-030 A combinational sub-module alu_negate_lane (ELEM_W, sat_mode, a -> y, ovf) SHALL be instantiated LANES times.
REQ-031 The beat counter SHALL be clog2(BEATS)+1 bits wide; no combinational path SHALL exist from A_flat to C_flat.

Verification
REQ-032 Defaults, A = all 0x01, sat_mode=0 -> done at T+6, C = all 0xFF, overflow_flag=0.
REQ-033 Defaults, element 7 = 0x80, all others 0x05, sat_mode=0 -> C[7]=0x80, others 0xFB, overflow_mask=25'h0000080, overflow_flag=1.
REQ-034 Same stimulus as REQ-033 with sat_mode=1 -> C[7]=0x7F, same mask, flag=1.
REQ-035 LANES=4, DIM=5 -> BEATS=7, done at T+8; element 24 (last, partial beat) = 0x10 -> C[24]=0xF0; no out-of-range writes.
REQ-036 Assert start again at T+2, and separately assert rst at T+3 -> the second start is ignored; after rst, busy=0 and C=0 with no done pulse; a fresh start afterwards completes normally.
REQ-037 Change A_flat at T+1 -> result reflects the A_flat value captured at T.
